// File: rtl/esc_multi.sv
// Multi-channel ESC/servo pulse generator: µs timebase, frame-synchronous command
// shadowing, arm sequencer. Optional watchdog enabled with ESC_WATCHDOG_EN.

module esc_multi_lane #(
    parameter int CMD_BITS = 10,
    parameter int UW       = 12,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                min_only,
    input  logic [CMD_BITS-1:0] active,
    input  logic [UW-1:0]       us,
    output logic                pulse
);
    logic [31:0] act32, span, width, eff;

    // 32-bit arithmetic so MIN_US + clamp can never wrap for any CMD_BITS
    assign act32 = 32'(active);
    assign span  = 32'(MAX_US - MIN_US);
    assign width = 32'(MIN_US) + ((act32 > span) ? span : act32);
    assign eff   = min_only ? 32'(MIN_US) : width;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse <= 1'b0;
        else        pulse <= en && (32'(us) < eff);
    end
endmodule

module esc_multi #(
    parameter int CHANNELS    = 4,
    parameter int CMD_BITS    = 10,
    parameter int CLK_DIV     = 50,
    parameter int FRAME_US    = 2500,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int ARM_FRAMES  = 200,
    parameter int WDOG_FRAMES = 50
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*CMD_BITS-1:0] cmd,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         arm,
    output logic                         armed,
    output logic                         frame_start,
    output logic [CHANNELS-1:0]          esc_out,
    output logic                         wdog_trip
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int UW = $clog2(FRAME_US);
    localparam int AW = $clog2(ARM_FRAMES + 1);

    if (FRAME_US <= MAX_US || MAX_US < MIN_US || CLK_DIV < 2 || ARM_FRAMES < 1 || WDOG_FRAMES < 1) begin : g_bad_cfg
        $error("esc_multi: invalid parameter set");
    end

    typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;

    state_t                             state_q, state_d;
    logic [AW-1:0]                      arm_cnt_q, arm_cnt_d;
    logic [DW-1:0]                      div_q;
    logic [UW-1:0]                      us_q;
    logic                               tick, boundary, accept, pending_q;
    logic [CHANNELS-1:0][CMD_BITS-1:0]  cmd_vec, shadow_q, active_q;

    assign cmd_vec   = cmd;
    assign tick      = (div_q == DW'(CLK_DIV - 1));
    assign boundary  = tick && (us_q == UW'(FRAME_US - 1));
    assign cmd_ready = !pending_q;
    assign accept    = cmd_valid && !pending_q;
    assign armed     = (state_q == ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            us_q        <= '0;
            frame_start <= 1'b0;
        end else begin
            div_q       <= tick ? '0 : div_q + 1'b1;
            frame_start <= boundary;
            if (tick) us_q <= boundary ? '0 : us_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DISARMED;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // arm is only looked at on frame boundaries so a pulse in flight is never cut
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (boundary) begin
            unique case (state_q)
                DISARMED: if (arm) begin
                    state_d   = ARMING;
                    arm_cnt_d = '0;
                end
                ARMING: if (!arm) state_d = DISARMED;
                else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    if (arm_cnt_d == AW'(ARM_FRAMES)) state_d = ARMED;
                end
                ARMED: if (!arm) state_d = DISARMED;
                default: state_d = DISARMED;
            endcase
        end
    end

`ifdef ESC_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_FRAMES + 1);
    logic [WW-1:0] wcnt_q;
    logic          wdog_q, wdog_fire;

    assign wdog_fire = boundary && !accept && (state_q == ARMED) && (wcnt_q == WW'(WDOG_FRAMES - 1));
    assign wdog_trip = wdog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else if (accept) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else if (boundary && state_q == ARMED && wcnt_q != WW'(WDOG_FRAMES)) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wdog_fire) wdog_q <= 1'b1;
        end
    end
`else
    logic wdog_fire;
    assign wdog_fire = 1'b0;
    assign wdog_trip = 1'b0;
`endif

    // boundary-cycle commands bypass the shadow and land straight in active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
        end else if (boundary) begin
            if (accept) active_q <= cmd_vec;
            else if (pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
            if (wdog_fire) active_q <= '0;
        end else if (accept) begin
            shadow_q  <= cmd_vec;
            pending_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        esc_multi_lane #(
            .CMD_BITS(CMD_BITS), .UW(UW), .MIN_US(MIN_US), .MAX_US(MAX_US)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (state_q != DISARMED),
            .min_only(state_q == ARMING),
            .active  (active_q[g]),
            .us      (us_q),
            .pulse   (esc_out[g])
        );
    end
endmodule

// File: tb/tb_esc_multi.sv
// Directed bench for esc_multi with scaled-down timing; a cycle-arithmetic model
// checks every output each cycle, plus literal pulse-width and period checks.

module tb_esc_multi;
    localparam int CH = 4, CB = 5, CD = 2, FU = 40, MN = 10, MX = 20, AF = 3, WF = 4;
    localparam int P  = CD * FU;

    logic              clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, arm = 1'b0;
    logic [CH*CB-1:0]  cmd = '0;
    logic              cmd_ready, armed, frame_start, wdog_trip;
    logic [CH-1:0]     esc_out;

    int total = 0, bad = 0;
    logic chk_on = 1'b0;

    esc_multi #(
        .CHANNELS(CH), .CMD_BITS(CB), .CLK_DIV(CD), .FRAME_US(FU),
        .MIN_US(MN), .MAX_US(MX), .ARM_FRAMES(AF), .WDOG_FRAMES(WF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .arm(arm), .armed(armed), .frame_start(frame_start), .esc_out(esc_out),
        .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: time is the count of edges since reset release; state is per frame.
    int n, m_state, m_acnt, m_pend, m_wcnt, m_trip;
    int m_active[CH], m_shadow[CH];
    logic [CH-1:0] exp_esc;
    logic exp_fs, exp_armed, exp_ready, exp_trip;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            n = 0; m_state = 0; m_acnt = 0; m_pend = 0; m_wcnt = 0; m_trip = 0;
            for (int i = 0; i < CH; i++) begin m_active[i] = 0; m_shadow[i] = 0; end
            exp_esc = '0; exp_fs = 0; exp_armed = 0; exp_ready = 1; exp_trip = 0;
        end else begin
            int u, w;
            bit bnd, acc, was_armed;
            u = (n / CD) % FU;
            bnd = ((n + 1) % P) == 0;
            acc = cmd_valid && (m_pend == 0);
            was_armed = (m_state == 2);
            for (int i = 0; i < CH; i++) begin
                w = (m_state == 1) ? MN : MN + ((m_active[i] > MX - MN) ? MX - MN : m_active[i]);
                exp_esc[i] = (m_state != 0) && (u < w);
            end
            if (bnd) begin
                if (m_state == 0) begin
                    if (arm) begin m_state = 1; m_acnt = 0; end
                end else if (m_state == 1) begin
                    if (!arm) m_state = 0;
                    else begin m_acnt++; if (m_acnt == AF) m_state = 2; end
                end else if (!arm) m_state = 0;
                for (int i = 0; i < CH; i++)
                    if (acc) m_active[i] = int'(cmd[i*CB +: CB]);
                    else if (m_pend != 0) m_active[i] = m_shadow[i];
                m_pend = 0;
            end else if (acc) begin
                for (int i = 0; i < CH; i++) m_shadow[i] = int'(cmd[i*CB +: CB]);
                m_pend = 1;
            end
`ifdef ESC_WATCHDOG_EN
            if (acc) begin m_wcnt = 0; m_trip = 0; end
            else if (bnd && was_armed && m_wcnt < WF) begin
                m_wcnt++;
                if (m_wcnt == WF) begin
                    m_trip = 1;
                    for (int i = 0; i < CH; i++) m_active[i] = 0;
                end
            end
`endif
            exp_fs = bnd; exp_armed = (m_state == 2); exp_ready = (m_pend == 0); exp_trip = (m_trip != 0);
            n++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && chk_on) begin
            chk("esc_out", 32'(esc_out), 32'(exp_esc));
            chk("frame_start", 32'(frame_start), 32'(exp_fs));
            chk("armed", 32'(armed), 32'(exp_armed));
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("wdog_trip", 32'(wdog_trip), 32'(exp_trip));
        end
    end

    function automatic logic [CH*CB-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [CH*CB-1:0] v;
        v = '0;
        v[0*CB +: CB] = CB'(a); v[1*CB +: CB] = CB'(b);
        v[2*CB +: CB] = CB'(c); v[3*CB +: CB] = CB'(d);
        return v;
    endfunction

    // call at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [CH*CB-1:0] c);
        int k;
        cmd = c; cmd_valid = 1'b1; k = 0;
        while (!cmd_ready && k < 4 * P) begin @(negedge clk); k++; end
        chk("send_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        @(negedge clk);
        while (!frame_start && k < 4 * P) begin @(negedge clk); k++; end
        chk("wait_fs", 32'(frame_start), 1);
    endtask

    // width in clk cycles of the next fresh pulse on channel ch
    task automatic measure(input int ch, output int w);
        int k;
        w = 0; k = 0;
        while (esc_out[ch] && k < 4 * P) begin @(negedge clk); k++; end
        k = 0;
        while (!esc_out[ch] && k < 4 * P) begin @(negedge clk); k++; end
        chk("pulse_rise", 32'(esc_out[ch]), 1);
        while (esc_out[ch] && w < 4 * P) begin w++; @(negedge clk); end
    endtask

    initial begin
        int cnt, w;
        repeat (3) @(negedge clk);
        chk("rst_esc", 32'(esc_out), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_wdog", 32'(wdog_trip), 0);
        rst_n = 1'b1; chk_on = 1'b1;

        // idle timebase
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!frame_start && cnt < 4 * P);
        chk("first_fs_cycles", cnt, P);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!frame_start && cnt < 4 * P);
        chk("fs_period", cnt, P);

        // arming: cmd 5 -> 15 us once armed
        send(pack4(5, 5, 5, 5));
        arm = 1'b1;
        measure(0, w); chk("arming_width", w, MN * CD);
        cnt = 0;
        while (!armed && cnt < 10 * P) begin @(negedge clk); cnt++; end
        chk("became_armed", 32'(armed), 1);
        measure(0, w); chk("armed_width", w, 30);

        // clamp: 0 / span / overrange / mid
        send(pack4(0, 10, 31, 7));
        measure(0, w); chk("clamp_ch0", w, 20);
        measure(1, w); chk("clamp_ch1", w, 40);
        measure(2, w); chk("clamp_ch2", w, 40);
        measure(3, w); chk("clamp_ch3", w, 34);

        // back-to-back: second stalls until the boundary
        send(pack4(3, 3, 3, 3));
        chk("stall_ready", 32'(cmd_ready), 0);
        send(pack4(8, 8, 8, 8));
        measure(0, w); chk("second_cmd_width", w, 36);

        // command on the boundary edge applies to that frame
        wait_fs();
        repeat (P - 1) @(negedge clk);
        cmd = pack4(2, 2, 2, 2); cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        measure(0, w); chk("boundary_cmd_width", w, 24);

        // disarm mid-pulse
        cnt = 0;
        while (!esc_out[0] && cnt < 2 * P) begin @(negedge clk); cnt++; end
        repeat (5) @(negedge clk);
        arm = 1'b0;
        chk("still_armed", 32'(armed), 1);
        wait_fs();
        chk("disarmed", 32'(armed), 0);
        cnt = 0;
        repeat (P - 2) begin @(negedge clk); if (esc_out != 0) cnt++; end
        chk("no_pulse_disarmed", cnt, 0);

        // async reset mid-pulse
        arm = 1'b1;
        wait_fs();
        cnt = 0;
        while (!esc_out[0] && cnt < 2 * P) begin @(negedge clk); cnt++; end
        repeat (3) @(negedge clk);
        chk("pre_reset_high", 32'(esc_out[0]), 1);
        rst_n = 1'b0;
        #1 chk("async_reset_esc", 32'(esc_out), 0);
        chk("async_reset_ready", 32'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        arm = 1'b0;
        rst_n = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!frame_start && cnt < 4 * P);
        chk("fs_after_reset", cnt, P);
        repeat (P) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/esc_multi.md
# esc_multi

Multi-channel ESC pulse generator, the parametrised successor to the single-channel `esc` block. It drives CHANNELS standard ESC/servo PWM outputs from one system clock, with an internal microsecond timebase and command clamping. A valid/ready command port loads a shadow register, which is applied to all channels together at each frame boundary. An arm/disarm sequencer emits minimum-throttle pulses for a fixed number of frames before commanded throttle is allowed through.

## Interface
- CHANNELS, 4, number of ESC outputs
- CMD_BITS, 10, throttle command width per channel
- CLK_DIV, 50, clk cycles per µs tick (50 MHz → 1 MHz)
- FRAME_US, 2500, frame period in µs (400 Hz)
- MIN_US, 1000, pulse width for command 0
- MAX_US, 2000, maximum pulse width
- ARM_FRAMES, 200, minimum-pulse frames before ARMED
- WDOG_FRAMES, 50, watchdog timeout in frames (used only with ESC_WATCHDOG_EN)

- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cmd  in  CHANNELS*CMD_BITS  packed commands; channel i at [i*CMD_BITS +: CMD_BITS]
- cmd_valid  in  1  cmd is valid
- cmd_ready  out  1  shadow register is free
- arm  in  1  arm request level
- armed  out  1  state is ARMED
- frame_start  out  1  one-cycle pulse at each frame boundary
- esc_out  out  CHANNELS  PWM outputs
- wdog_trip  out  1  watchdog has fired (sticky until next accepted command)

## Operation
- Reset values: esc_out=0, armed=0, frame_start=0, wdog_trip=0, cmd_ready=1. Counters, active and shadow registers are 0. State is DISARMED.
- Timebase: div counter runs 0..CLK_DIV-1 and raises `tick` at CLK_DIV-1. us_cnt runs 0..FRAME_US-1 and advances on each tick. When it wraps, us_cnt becomes 0 and frame_start is registered high for that one cycle (the boundary edge).
- Width per channel: width_i = MIN_US + min(active_i, MAX_US-MIN_US). Compute at full width with no overflow.
- Handshake: cmd_ready = ~pending.
  - valid&&ready on a non-boundary edge captures cmd into the shadow register and sets pending.
  - At a boundary with pending=1, shadow is copied to active and pending is cleared.
  - valid&&ready on the boundary edge itself loads cmd directly into active and leaves pending at 0.
  - cmd is ignored while cmd_ready=0.
- States are evaluated only at boundary edges:
  - DISARMED: arm=1 → ARMING and clear the arm counter.
  - ARMING: arm=0 → DISARMED. Otherwise increment the arm counter; after ARM_FRAMES frames → ARMED.
  - ARMED: arm=0 → DISARMED.
- Output: esc_out[i] <= (state≠DISARMED) && (us_cnt < eff_width_i), registered.
  - eff_width_i = MIN_US in ARMING, width_i in ARMED.
  - A pulse already in progress always completes; arm changes mid-frame take effect only at the next boundary.
- Commands are accepted in every state. active updates in DISARMED and ARMING as well, but only ARMED uses it.

## Timing
- First tick occurs CLK_DIV cycles after reset release. First frame_start occurs FRAME_US*CLK_DIV cycles after reset release.
- esc_out rises 1 clk after frame_start and stays high for exactly eff_width*CLK_DIV clk cycles. All channels rise on the same edge.
- Command latency: an accepted command affects pulses from the next boundary (same-cycle boundary acceptance: that frame's pulse).
- armed asserts on the boundary edge that ends the ARM_FRAMES-th ARMING frame. It deasserts on the first boundary with arm=0.
- rst_n asserted mid-pulse forces esc_out low asynchronously. Sequencing restarts from DISARMED.
- Parameter constraints: FRAME_US > MAX_US ≥ MIN_US, CLK_DIV ≥ 2.

## Configuration
- ESC_WATCHDOG_EN defined:
  - A frame counter clears on each accepted command and increments at each boundary while ARMED.
  - On reaching WDOG_FRAMES it sets wdog_trip and zeroes all active commands at that boundary, giving MIN_US pulses.
  - The counter saturates. The next accepted command clears wdog_trip.
- ESC_WATCHDOG_EN undefined: there is no watchdog logic, wdog_trip is tied 0, and active values persist indefinitely.

## Test plan
- Reset and idle: rst_n low, then release with arm=0 → esc_out=0 for 3 frames; frame_start every 125000 clk; cmd_ready=1.
- Arming: arm=1 and cmd=all 500 → 200 frames of 50000-clk pulses on all channels, then armed=1 and 75000-clk pulses (1500 µs).
- Clamping and width: armed, ch0=0, ch1=1000, ch2=1023, ch3=700 → pulses 1000/2000/2000/1700 µs.
- Handshake: two commands back-to-back mid-frame → second stalls (cmd_ready=0) until boundary; command sent on boundary cycle applies to that frame.
- Disarm and reset mid-pulse: arm drops at us_cnt=300 → current pulse completes, armed falls at next boundary, outputs stay low. rst_n low at us_cnt=500 → esc_out=0 immediately.
- Watchdog (ESC_WATCHDOG_EN): armed, no commands for 50 frames → wdog_trip=1 and 1000 µs pulses; a new command clears wdog_trip.
